// File: rtl/lsu.sv
//==============================================================================
// Module   : lsu
// Purpose  : RV32 load/store unit; one valid/ready word-bus transaction per
//            access, with local rejection of misaligned or illegal accesses.
// Revision : 1.0
//==============================================================================
`default_nettype none

module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic        r_write;
  logic [2:0]  r_op;
  logic [1:0]  r_off;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic        w_illegal;
  logic        w_accept;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic        w_sext;
  logic [31:0] w_load;

  always_comb begin
    w_illegal = (req_op == 3'b011) || (req_op == 3'b110) || (req_op == 3'b111)
             || (req_write && req_op[2])
             || ((req_op[1:0] == 2'b01) && req_addr[0])
             || ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_strb  = 4'b1111;
    w_wdata = req_wdata;
    case (req_op[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << req_addr[1:0];
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
    if (!req_write) begin
      w_strb = 4'b0000;
    end
  end

  // Move the addressed lane down to bit 0, then extend by size and signedness.
  assign w_shift = bus_rdata >> {r_off, 3'b000};
  assign w_sext  = ~r_op[2];

  always_comb begin
    w_load = w_shift;
    case (r_op[1:0])
      2'b00:   w_load = {{24{w_sext & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = {{16{w_sext & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_illegal ? S_DONE : S_REQ;
      S_REQ:  if (bus_ready) w_next = r_write ? S_DONE : S_WAIT;
      S_WAIT: if (bus_rvalid) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_op    <= 3'b000;
      r_off   <= 2'b00;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_err <= w_illegal;
        // Bus-facing registers are only reloaded for accesses that will use the bus.
        if (!w_illegal) begin
          r_write <= req_write;
          r_op    <= req_op;
          r_off   <= req_addr[1:0];
          r_addr  <= {req_addr[31:2], 2'b00};
          r_wstrb <= w_strb;
          r_wdata <= w_wdata;
        end
      end
      if ((r_state == S_WAIT) && bus_rvalid) begin
        r_rdata <= w_load;
      end
    end
  end

  assign bus_valid = (r_state == S_REQ);
  assign bus_wen   = r_write;
  assign bus_addr  = r_addr;
  assign bus_wstrb = r_wstrb;
  assign bus_wdata = r_wdata;
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_DONE) && r_err;
  assign rdata     = r_rdata;
  assign stall     = w_accept || (r_state == S_REQ) || (r_state == S_WAIT);

endmodule

`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle RV32 core. It is the memory-side counterpart of the decoder's `mem_write`/`mem_op` outputs. The core presents a decoded load or store together with its address and store data. The unit stalls the core, runs one transaction on a valid/ready word bus with a separate read-response strobe, and returns the sign- or zero-extended load result. Misaligned accesses and illegal `mem_op` codes are rejected locally without issuing a bus transaction.

## Interface
Parameters: none (XLEN fixed at 32).

Clock and reset: one clock; reset is asynchronous and active-high (`clk`, `rst`).

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: current instruction is a load or store.
- `req_write` in 1: 1 = store, 0 = load (decoder `mem_write`).
- `req_op` in 3: decoder `mem_op`.
  - 000 = byte signed; 001 = half signed; 010 = word; 100 = byte unsigned; 101 = half unsigned.
  - Stores use only 000/001/010.
- `req_addr` in 32: byte address (ALU result).
- `req_wdata` in 32: store data, taken from rs2.
- `stall` out 1: holds the core PC/regfile write; combinational.
- `done` out 1: one-cycle pulse; the access completed this cycle.
- `err` out 1: one-cycle pulse with `done`; access was misaligned or had an illegal op.
- `rdata` out 32: extended load result; holds its value until the next `done`.
- `bus_valid` out 1: request valid.
- `bus_ready` in 1: request accepted.
- `bus_wen` out 1: request is a write.
- `bus_addr` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `bus_wstrb` out 4: byte enables (writes only; 0000 on reads).
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rvalid` in 1: read response valid.
- `bus_rdata` in 32: read response word.

## Operation
States: IDLE, REQ, WAIT, DONE; encoding is free.
- IDLE:
  - `req_valid` with a legal, aligned access: latch write flag, op, addr[1:0], wstrb and wdata; bus outputs load; go to REQ.
  - `req_valid` with an illegal access: go to DONE with the error flag set.
- Illegal access rules:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - `req_op` ∈ {011, 110, 111}.
  - Store with `req_op`[2]=1.
- REQ:
  - `bus_valid`=1 while in REQ.
  - All bus outputs stay stable until `bus_ready`.
  - On `bus_ready`: a store goes to DONE; a load goes to WAIT.
- WAIT: on `bus_rvalid`, capture the extracted and extended `bus_rdata` into `rdata`, then go to DONE.
- DONE: `done`=1 and `stall`=0; go to IDLE unconditionally.
- `stall` = (IDLE & `req_valid`) | REQ | WAIT.
- Store strobes:
  - sb: 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - sh: 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - sw: 1111, wdata unchanged.
- Load extraction:
  - Source data is `bus_rdata` >> (8·addr[1:0]).
  - Bytes use bits [7:0]; halves use bits [15:0].
  - Extension: ops 000/001 sign-extend; ops 100/101 zero-extend.
- Stores and errored accesses leave `rdata` unchanged.
- Errored access: no bus activity; `err`=`done`=1 in DONE.

## Timing
- Reset (asynchronous): state=IDLE and all registered outputs cleared.
  - `done`=`err`=`bus_valid`=`bus_wen`=0.
  - `rdata`=`bus_addr`=`bus_wdata`=0 and `bus_wstrb`=0000.
  - `stall` follows `req_valid` while in IDLE.
- Minimum latency, counted from the `req_valid` cycle to the `done` cycle:
  - Store: 2 cycles (`bus_ready` already high in REQ).
  - Load: 3 cycles (`bus_rvalid` in the first WAIT cycle).
  - Errored access: 1 cycle.
- Each cycle in REQ without `bus_ready`, or in WAIT without `bus_rvalid`, adds one cycle; there is no timeout.
- `bus_rvalid` is accepted only in WAIT. It is ignored in IDLE, REQ and DONE; a stale response after reset is dropped.
- `req_valid` is ignored in DONE (same instruction, committing). A new request is sampled only in IDLE.
- Reset during REQ or WAIT:
  - The transaction is abandoned and `bus_valid` drops immediately.
  - No `done` pulse is produced.
- `bus_ready` and `bus_rvalid` are never both required in the same cycle; a load always spends at least one cycle in WAIT.

## Test plan
- lw addr 0x8000_0004, bus returns 0xDEAD_BEEF in the first WAIT cycle:
  - `bus_addr`=0x8000_0004, `bus_wstrb`=0000.
  - `done` 3 cycles after `req_valid`, `rdata`=0xDEAD_BEEF.
- lb addr 0x…03 returning 0x80FF_FFFF → `rdata`=0xFFFF_FF80. Same access with lbu → `rdata`=0x0000_0080.
- sh addr 0x…02, wdata 0x1234_ABCD, `bus_ready` held low 3 cycles:
  - `bus_wstrb`=1100, `bus_wdata`=0xABCD_ABCD, outputs stable throughout.
  - `done` 5 cycles after `req_valid`.
- lw addr 0x…01:
  - `done`=`err`=1 the next cycle, `bus_valid` never asserted, `rdata` unchanged.
  - `req_op`=011 gives the same response.
- Reset asserted while in WAIT:
  - `bus_valid`/`done` go to 0; a following `bus_rvalid` is ignored.
  - The next lw completes normally.
- Back-to-back sw then lw with no idle gap between instructions: two separate bus transactions, each with its own `done` pulse and correct `stall` shape.
